ahb_default_slave_p: RTL and testbench

Parametrised AHB-Lite default slave for the DES bus fabric. It is selected by the decoder for any unmapped address. Every NONSEQ/SEQ transfer gets the protocol two-cycle ERROR response, optionally preceded by programmable wait states. IDLE/BUSY transfers get a zero-wait OKAY. This successor generalises data/address width and wait states, and can log faulting accesses for debug.

---
 rtl/ahb_pkg.sv | 22 ++
 rtl/ahb_err_logger.sv | 43 ++++
 rtl/ahb_default_slave_p.sv | 125 ++++++++++++
 tb/tb_ahb_default_slave_p.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the DES bus fabric: transfer types,
// response encodings and the default-slave state encoding.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DSLV_IDLE = 2'b00,
    DSLV_WAIT = 2'b01,
    DSLV_ERR1 = 2'b10,
    DSLV_ERR2 = 2'b11
  } dslv_state_t;

endpackage

// File: rtl/ahb_err_logger.sv
// Debug log for the default slave: remembers the address and direction of
// the most recent errored transfer and keeps a saturating count of them.
// Only instantiated when DEFAULT_SLAVE_ERROR_LOG_EN is defined.
module ahb_err_logger #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  log_en,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  write_in,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  write
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Capture a new fault, or wipe the log; a clear on the same edge as a new
  // fault wipes the old history first so the new fault counts as the first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      addr  <= '0;
      write <= 1'b0;
    end else if (log_en) begin
      addr  <= addr_in;
      write <= write_in;
      if (clear) begin
        count <= CNT_WIDTH'(1);
      end else if (count != CNT_MAX) begin
        count <= count + CNT_WIDTH'(1);
      end
    end else if (clear) begin
      count <= '0;
      addr  <= '0;
      write <= 1'b0;
    end
  end

endmodule

// File: rtl/ahb_default_slave_p.sv
// AHB-Lite default slave: answers every NONSEQ/SEQ transfer to an unmapped
// address with optional wait states followed by the two-cycle ERROR
// response, and answers IDLE/BUSY with a zero-wait OKAY.
// Optional fault log enabled by defining DEFAULT_SLAVE_ERROR_LOG_EN.
module ahb_default_slave_p
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic                  HREADY,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic                  HMASTLOCK,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
`ifdef DEFAULT_SLAVE_ERROR_LOG_EN
  ,
  input  logic                  err_clear,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_write
`endif
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dslv_state_t state;
  dslv_state_t state_nxt;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_cnt_nxt;
  htrans_t     trans;
  logic        accept;
  logic        start_err;

  assign trans  = htrans_t'(HTRANS);
  assign accept = HSEL && HREADY && ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));

  // State and wait-counter registers; reset aborts any response in flight.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= DSLV_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state logic: a new transfer is only taken where HREADYOUT is high
  // (IDLE or the final ERROR cycle), so a master that keeps issuing transfers
  // during ERR2 gets back-to-back errors with no OKAY cycle between them.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    start_err    = 1'b0;
    case (state)
      DSLV_IDLE, DSLV_ERR2: begin
        if (accept) begin
          start_err = 1'b1;
          if (WAIT_STATES > 0) begin
            state_nxt    = DSLV_WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end else begin
            state_nxt = DSLV_ERR1;
          end
        end else begin
          state_nxt = DSLV_IDLE;
        end
      end
      DSLV_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt = DSLV_ERR1;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      DSLV_ERR1: begin
        state_nxt = DSLV_ERR2;
      end
      default: begin
        state_nxt = DSLV_IDLE;
      end
    endcase
  end

  assign HREADYOUT = !((state == DSLV_WAIT) || (state == DSLV_ERR1));
  assign HRESP     = ((state == DSLV_ERR1) || (state == DSLV_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = '0;

`ifdef DEFAULT_SLAVE_ERROR_LOG_EN
  logic unused_inputs;
  assign unused_inputs = ^{HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA};

  ahb_err_logger #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_logger (
    .clk      (HCLK),
    .rst      (HRESET),
    .log_en   (start_err),
    .clear    (err_clear),
    .addr_in  (HADDR),
    .write_in (HWRITE),
    .count    (err_count),
    .addr     (err_addr),
    .write    (err_write)
  );
`else
  logic unused_inputs;
  assign unused_inputs = ^{HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HADDR, HWRITE, start_err};
`endif

endmodule

// File: tb/tb_ahb_default_slave_p.sv
// Bench for ahb_default_slave_p. Two instances share the bus inputs:
// dut0 with no wait states and a 2-bit error counter, dut1 with three wait
// states. Log checks are active when DEFAULT_SLAVE_ERROR_LOG_EN is defined.
module tb_ahb_default_slave_p;

  localparam int WS0 = 0;
  localparam int WS1 = 3;
  localparam int CMAX0 = 3;
  localparam int CMAX1 = 65535;

  logic        clk;
  logic        rst;
  logic        hsel;
  logic        hready;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [63:0] hwdata;
  logic        err_clear;

  logic        rdy0, rdy1, resp0, resp1;
  logic [63:0] hrdata0, hrdata1;
`ifdef DEFAULT_SLAVE_ERROR_LOG_EN
  logic [1:0]  errcnt0;
  logic [15:0] errcnt1;
  logic [31:0] erraddr0, erraddr1;
  logic        errwr0, errwr1;
`endif

  int checks = 0;
  int errors = 0;

  // Per-cycle expectation for both instances.
  typedef struct packed {
    logic [1:0]       rdy;
    logic [1:0]       resp;
    logic [1:0][15:0] cnt;
    logic [1:0][31:0] addr;
    logic [1:0]       wr;
  } exp_t;

  exp_t expq[$];

  // Reference model: cycles left in the current data phase, plus log contents.
  int          left [2];
  int          mcnt [2];
  logic [31:0] maddr[2];
  logic        mwr  [2];

  ahb_default_slave_p #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .WAIT_STATES(WS0), .CNT_WIDTH(2)
  ) dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HREADY(hready), .HTRANS(htrans),
    .HWRITE(hwrite), .HADDR(haddr), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HMASTLOCK(hmastlock), .HWDATA(hwdata), .HREADYOUT(rdy0), .HRESP(resp0),
    .HRDATA(hrdata0)
`ifdef DEFAULT_SLAVE_ERROR_LOG_EN
    , .err_clear(err_clear), .err_count(errcnt0), .err_addr(erraddr0), .err_write(errwr0)
`endif
  );

  ahb_default_slave_p #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .WAIT_STATES(WS1), .CNT_WIDTH(16)
  ) dut1 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HREADY(hready), .HTRANS(htrans),
    .HWRITE(hwrite), .HADDR(haddr), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HMASTLOCK(hmastlock), .HWDATA(hwdata), .HREADYOUT(rdy1), .HRESP(resp1),
    .HRDATA(hrdata1)
`ifdef DEFAULT_SLAVE_ERROR_LOG_EN
    , .err_clear(err_clear), .err_count(errcnt1), .err_addr(erraddr1), .err_write(errwr1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t expFromModel();
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      // left: 0 = idle, 1 = final ERROR cycle, 2 = first ERROR cycle, >2 = wait
      e.rdy[d]  = (left[d] <= 1);
      e.resp[d] = (left[d] == 1) || (left[d] == 2);
      e.cnt[d]  = 16'(mcnt[d]);
      e.addr[d] = maddr[d];
      e.wr[d]   = mwr[d];
    end
    return e;
  endfunction

  task automatic resetModel();
    for (int d = 0; d < 2; d++) begin
      left[d]  = 0;
      mcnt[d]  = 0;
      maddr[d] = '0;
      mwr[d]   = 1'b0;
    end
  endtask

  // Advance the model over one rising edge using the inputs driven before it.
  task automatic modelEdge();
    logic acc;
    logic eff;
    int   ws;
    int   cmax;
    acc = hsel && hready && htrans[1];
    for (int d = 0; d < 2; d++) begin
      ws   = (d == 0) ? WS0 : WS1;
      cmax = (d == 0) ? CMAX0 : CMAX1;
      eff  = acc && (left[d] <= 1);
      if (left[d] > 1) left[d] = left[d] - 1;
      else if (acc)    left[d] = ws + 2;
      else             left[d] = 0;
      if (err_clear) begin
        mcnt[d]  = 0;
        maddr[d] = '0;
        mwr[d]   = 1'b0;
      end
      if (eff) begin
        mcnt[d]  = (mcnt[d] < cmax) ? mcnt[d] + 1 : cmax;
        maddr[d] = haddr;
        mwr[d]   = hwrite;
      end
    end
    expq.push_back(expFromModel());
  endtask

  task automatic applyStimulus(input logic sel, input logic rdy, input logic [1:0] trans,
                               input logic wr, input logic [31:0] addr, input logic clr);
    hsel      = sel;
    hready    = rdy;
    htrans    = trans;
    hwrite    = wr;
    haddr     = addr;
    err_clear = clr;
    hsize     = 3'($urandom_range(0, 7));
    hburst    = 3'($urandom_range(0, 7));
    hprot     = 4'($urandom_range(0, 15));
    hmastlock = 1'($urandom_range(0, 1));
    hwdata    = {$urandom, $urandom};
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic releaseReset();
    rst = 1'b0;
    resetModel();
    expq.push_back(expFromModel());
  endtask

  task automatic doReset();
    rst       = 1'b1;
    hsel      = 1'b0;
    hready    = 1'b1;
    htrans    = 2'b00;
    hwrite    = 1'b0;
    haddr     = '0;
    err_clear = 1'b0;
    expq.delete();
    repeat (2) @(posedge clk);
    #1;
    releaseReset();
  endtask

  // Asynchronous reset between edges; outputs must return to idle at once.
  task automatic midReset();
    #2;
    rst = 1'b1;
    expq.delete();
    #1;
    checkOutput("async_rst_rdy0", 64'(rdy0), 64'd1);
    checkOutput("async_rst_resp0", 64'(resp0), 64'd0);
    checkOutput("async_rst_rdy1", 64'(rdy1), 64'd1);
    checkOutput("async_rst_resp1", 64'(resp1), 64'd0);
    checkOutput("async_rst_hrdata0", hrdata0, 64'd0);
`ifdef DEFAULT_SLAVE_ERROR_LOG_EN
    checkOutput("async_rst_cnt0", 64'(errcnt0), 64'd0);
    checkOutput("async_rst_cnt1", 64'(errcnt1), 64'd0);
`endif
    hsel      = 1'b0;
    htrans    = 2'b00;
    err_clear = 1'b0;
    @(posedge clk);
    #1;
    releaseReset();
  endtask

  // Monitor: every cycle the DUTs present a response, compare it against the
  // oldest expectation in the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (expq.size() > 0)) begin
      e = expq.pop_front();
      checkOutput("hreadyout0", 64'(rdy0), 64'(e.rdy[0]));
      checkOutput("hresp0", 64'(resp0), 64'(e.resp[0]));
      checkOutput("hrdata0", hrdata0, 64'd0);
      checkOutput("hreadyout1", 64'(rdy1), 64'(e.rdy[1]));
      checkOutput("hresp1", 64'(resp1), 64'(e.resp[1]));
      checkOutput("hrdata1", hrdata1, 64'd0);
`ifdef DEFAULT_SLAVE_ERROR_LOG_EN
      checkOutput("err_count0", 64'(errcnt0), 64'(e.cnt[0]));
      checkOutput("err_addr0", 64'(erraddr0), 64'(e.addr[0]));
      checkOutput("err_write0", 64'(errwr0), 64'(e.wr[0]));
      checkOutput("err_count1", 64'(errcnt1), 64'(e.cnt[1]));
      checkOutput("err_addr1", 64'(erraddr1), 64'(e.addr[1]));
      checkOutput("err_write1", 64'(errwr1), 64'(e.wr[1]));
`endif
    end
  end

  initial begin
    hsize = '0; hburst = '0; hprot = '0; hmastlock = 1'b0; hwdata = '0;
    resetModel();
    doReset();

    // IDLE and BUSY transfers while selected
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, (i < 2) ? 2'b00 : 2'b01, 1'b0, 32'h100, 1'b0);

    // single NONSEQ read, then NONSEQ write
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_F000, 1'b0);
    idleCycles(6);
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b1, 32'h1234_5678, 1'b0);
    idleCycles(6);

    // master keeps issuing transfers: back-to-back errors, then return to IDLE
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, (i % 2) ? 2'b11 : 2'b10, i[0], 32'hA000 + 32'(i), 1'b0);
    idleCycles(6);

    // HREADY low or HSEL low must not start a transfer
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'hBAD0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'hBAD4, 1'b0);
    idleCycles(2);

    // enough errors to saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b10, 1'b1, 32'hC000 + 32'(i * 4), 1'b0);
      idleCycles(5);
    end

    // clear coincident with accept, then clear alone
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'hD00D, 1'b1);
    idleCycles(6);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 1'b1);
    idleCycles(2);

    // reset while dut0 is in its first ERROR cycle
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b1, 32'hE000, 1'b0);
    midReset();
    idleCycles(2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                    1'($urandom_range(0, 15) == 0));
    end
    idleCycles(6);
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
